// File: rtl/turbo_llr_pkg.sv
// rtl/turbo_llr_pkg.sv - shared types and sizing helpers for the turbo LLR frame loader
package turbo_llr_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } loader_state_t;

    // Rows of the y array: systematic plus (NOUT-1) parity rows per constituent code.
    function automatic int STREAMS_F(input int nout);
        return 1 + 2 * (nout - 1);
    endfunction

    // Columns of the y array: information bits plus tail symbols.
    function automatic int SYMBOLS_F(input int n, input int tail_bits);
        return n + tail_bits;
    endfunction

    // Width of an index that counts 0..count-1, never narrower than one bit.
    function automatic int IDX_W(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/llr_beat_counter.sv
// rtl/llr_beat_counter.sv - stream/symbol position counter for symbol-major LLR beats
module llr_beat_counter
    import turbo_llr_pkg::*;
#(
    parameter int STREAMS = 3,
    parameter int SYMBOLS = 19,
    localparam int SW = IDX_W(STREAMS),
    localparam int YW = IDX_W(SYMBOLS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          clear,
    output logic [SW-1:0] stream_idx,
    output logic [YW-1:0] sym_idx,
    output logic          last_beat
);

    logic stream_wrap;
    logic sym_wrap;

    // Wrap points of the inner (stream) and outer (symbol) indices.
    always_comb begin
        stream_wrap = (stream_idx == SW'(STREAMS - 1));
        sym_wrap    = (sym_idx == YW'(SYMBOLS - 1));
        last_beat   = stream_wrap && sym_wrap;
    end

    // Stream index runs fastest; symbol index steps each time the stream index wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stream_idx <= '0;
            sym_idx    <= '0;
        end else if (clear) begin
            stream_idx <= '0;
            sym_idx    <= '0;
        end else if (advance) begin
            if (stream_wrap) begin
                stream_idx <= '0;
                sym_idx    <= sym_wrap ? '0 : sym_idx + 1'b1;
            end else begin
                stream_idx <= stream_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/turbo_llr_frame_loader.sv
// rtl/turbo_llr_frame_loader.sv - serial LLR frame assembler and decoder handshake; optional TURBO_LLR_FRAME_CHECK_EN
module turbo_llr_frame_loader
    import turbo_llr_pkg::*;
#(
    parameter int BITS        = 32,
    parameter int N           = 17,
    parameter int TAIL_BITS   = 2,
    parameter int NOUT        = 2,
    parameter int DEC_TIMEOUT = 1023,
    localparam int STREAMS    = STREAMS_F(NOUT),
    localparam int SYMBOLS    = SYMBOLS_F(N, TAIL_BITS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BITS-1:0] s_llr,
    input  logic            s_last,
    input  logic            dec_done,
    output logic            in_valid,
    output logic [BITS-1:0] y [STREAMS][SYMBOLS],
    output logic [15:0]     frame_count,
    output logic            timeout_err,
    output logic            frame_err
);

    localparam int SW = IDX_W(STREAMS);
    localparam int YW = IDX_W(SYMBOLS);
    localparam int TW = IDX_W(DEC_TIMEOUT + 1);

    loader_state_t   state_q;
    loader_state_t   state_d;
    logic [SW-1:0]   stream_idx;
    logic [YW-1:0]   sym_idx;
    logic            last_beat;
    logic            beat_fire;
    logic            beat_bad;
    logic            beat_ok;
    logic            timer_expired;
    logic [TW-1:0]   timer_q;
    logic [BITS-1:0] frame_buf [STREAMS][SYMBOLS];

    // Input is accepted only while filling; reset forces ready low immediately.
    always_comb begin
        s_ready   = (state_q == FILL) && !reset;
        beat_fire = s_valid && s_ready;
    end

`ifdef TURBO_LLR_FRAME_CHECK_EN
    // A beat whose s_last disagrees with its frame position is a framing error.
    always_comb begin
        beat_bad = beat_fire && (s_last != last_beat);
    end
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign beat_bad      = 1'b0;
`endif

    // Good beats advance the position; dropped beats restart the frame.
    always_comb begin
        beat_ok       = beat_fire && !beat_bad;
        timer_expired = (timer_q == TW'(DEC_TIMEOUT - 1));
    end

    llr_beat_counter #(
        .STREAMS(STREAMS),
        .SYMBOLS(SYMBOLS)
    ) u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .advance   (beat_ok),
        .clear     (beat_bad),
        .stream_idx(stream_idx),
        .sym_idx   (sym_idx),
        .last_beat (last_beat)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill until the final beat, one issue cycle, then wait for done or expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (beat_ok && last_beat) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (dec_done || timer_expired) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Frame buffer; contents before the first full frame are never presented.
    always_ff @(posedge clk) begin
        if (beat_ok) begin
            frame_buf[stream_idx][sym_idx] <= s_llr;
        end
    end

    // Present the frame for exactly the strobe cycle and zeros otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_valid <= 1'b0;
            for (int s = 0; s < STREAMS; s++) begin
                for (int t = 0; t < SYMBOLS; t++) begin
                    y[s][t] <= '0;
                end
            end
        end else if (state_q == ISSUE) begin
            in_valid <= 1'b1;
            y        <= frame_buf;
        end else begin
            in_valid <= 1'b0;
            for (int s = 0; s < STREAMS; s++) begin
                for (int t = 0; t < SYMBOLS; t++) begin
                    y[s][t] <= '0;
                end
            end
        end
    end

    // Watchdog and completion bookkeeping; dec_done outranks a simultaneous expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q     <= '0;
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else if (state_q == WAIT) begin
            if (dec_done) begin
                frame_count <= frame_count + 16'd1;
                timer_q     <= '0;
            end else if (timer_expired) begin
                timeout_err <= 1'b1;
                timer_q     <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end else begin
            timer_q <= '0;
        end
    end

    // One-cycle framing error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= beat_bad;
        end
    end

endmodule

// File: tb/tb_turbo_llr_frame_loader.sv
// tb/tb_turbo_llr_frame_loader.sv - directed self-checking bench for turbo_llr_frame_loader
module tb_turbo_llr_frame_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [31:0] s_llr;
    logic        s_last;
    logic        dec_done;

    logic        s_ready;
    logic        in_valid;
    logic [31:0] y [3][19];
    logic [15:0] frame_count;
    logic        timeout_err;
    logic        frame_err;

    logic        wd_s_ready;
    logic        wd_in_valid;
    logic [31:0] wd_y [3][19];
    logic [15:0] wd_frame_count;
    logic        wd_timeout_err;
    logic        wd_frame_err;

    int n_checks = 0;
    int n_err    = 0;
    int pulses   = 0;
    int stalls   = 0;
    int ready_hits;
    int p0;

    turbo_llr_frame_loader dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_llr      (s_llr),
        .s_last     (s_last),
        .dec_done   (dec_done),
        .in_valid   (in_valid),
        .y          (y),
        .frame_count(frame_count),
        .timeout_err(timeout_err),
        .frame_err  (frame_err)
    );

    turbo_llr_frame_loader #(.DEC_TIMEOUT(8)) dut_wd (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (wd_s_ready),
        .s_llr      (s_llr),
        .s_last     (s_last),
        .dec_done   (dec_done),
        .in_valid   (wd_in_valid),
        .y          (wd_y),
        .frame_count(wd_frame_count),
        .timeout_err(wd_timeout_err),
        .frame_err  (wd_frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (in_valid === 1'b1) pulses++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // IEEE single bits of a positive integer below 2^24.
    function automatic logic [31:0] fbits(input int v);
        int e;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((v - (1 << e)) << (23 - e))};
    endfunction

    function automatic int y_mism(input int base);
        int m;
        m = 0;
        for (int i = 0; i < 57; i++)
            if (y[i % 3][i / 3] !== fbits(base + i + 1)) m++;
        return m;
    endfunction

    function automatic int y_nonzero();
        int m;
        m = 0;
        for (int s = 0; s < 3; s++)
            for (int t = 0; t < 19; t++)
                if (y[s][t] !== 32'd0) m++;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int base, input int first, input int stop, input int last_at, input bit gaps);
        int w;
        for (int i = first; i < stop; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) begin
                    s_valid = 1'b0;
                    step();
                end
            end
            s_valid = 1'b1;
            s_llr   = fbits(base + i + 1);
            s_last  = (i == last_at);
            w = 0;
            while (s_ready !== 1'b1 && w < 100) begin
                step();
                w++;
            end
            if (w >= 100) stalls++;
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic issue_check(input string tag, input int base);
        step();
        chk({tag, "_strobe"}, in_valid, 1);
        chk({tag, "_y"}, y_mism(base), 0);
        step();
        chk({tag, "_strobe_end"}, in_valid, 0);
        chk({tag, "_y_clear"}, y_nonzero(), 0);
    endtask

    task automatic finish_frame(input int delay);
        repeat (delay) step();
        dec_done = 1'b1;
        step();
        dec_done = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        s_valid  = 1'b0;
        s_llr    = 32'd0;
        s_last   = 1'b0;
        dec_done = 1'b0;
        step();
        step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_in_valid", in_valid, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_y_zero", y_nonzero(), 0);
        reset = 1'b0;
        #1;
        chk("fill_ready", s_ready, 1);

        // single frame, s_valid continuously high
        feed(0, 0, 57, 56, 1'b0);
        chk("t1_ready_drop", s_ready, 0);
        chk("t1_pre_strobe", in_valid, 0);
        chk("t1_y_pre_zero", y_nonzero(), 0);
        s_valid = 1'b1;
        s_llr   = fbits(1001);
        step();
        chk("t1_strobe", in_valid, 1);
        chk("t1_y_1_4", y[1][4], 32'h4160_0000);
        chk("t1_y_all", y_mism(0), 0);
        step();
        chk("t1_strobe_end", in_valid, 0);
        chk("t1_y_post_zero", y_nonzero(), 0);

        // backpressure while waiting; dec_done 40 cycles after the strobe
        ready_hits = 0;
        for (int j = 0; j < 38; j++) begin
            if (s_ready === 1'b1) ready_hits++;
            step();
        end
        if (s_ready === 1'b1) ready_hits++;
        chk("t2_hold_off", ready_hits, 0);
        dec_done = 1'b1;
        step();
        dec_done = 1'b0;
        chk("t2_frame_count", frame_count, 1);
        chk("t2_ready_back", s_ready, 1);
        feed(1000, 0, 57, 56, 1'b0);
        issue_check("t2", 1000);
        finish_frame(3);
        chk("t2_frame_count2", frame_count, 2);

        // three frames with random input gaps
        pulse_reset();
        p0 = pulses;
        for (int f = 0; f < 3; f++) begin
            feed(2000 + f * 100, 0, 57, 56, 1'b1);
            step();
            chk("t3_strobe", in_valid, 1);
            chk("t3_y", y_mism(2000 + f * 100), 0);
            finish_frame(19);
        end
        chk("t3_pulses", pulses - p0, 3);
        chk("t3_frame_count", frame_count, 3);

        // watchdog expiry with DEC_TIMEOUT=8
        pulse_reset();
        feed(3000, 0, 57, 56, 1'b0);
        step();
        chk("t4_wd_strobe", wd_in_valid, 1);
        repeat (7) step();
        chk("t4_wd_still_wait", wd_s_ready, 0);
        step();
        chk("t4_wd_back_fill", wd_s_ready, 1);
        chk("t4_wd_timeout", wd_timeout_err, 1);
        chk("t4_wd_count", wd_frame_count, 0);
        repeat (3) step();
        chk("t4_wd_sticky", wd_timeout_err, 1);

        // dec_done on the final watchdog cycle wins
        pulse_reset();
        chk("t4v_rst_timeout", wd_timeout_err, 0);
        feed(3000, 0, 57, 56, 1'b0);
        step();
        repeat (7) step();
        dec_done = 1'b1;
        step();
        dec_done = 1'b0;
        chk("t4v_timeout", wd_timeout_err, 0);
        chk("t4v_count", wd_frame_count, 1);
        chk("t4v_ready", wd_s_ready, 1);
        chk("t4v_main_count", frame_count, 1);

        // asynchronous reset after beat 30
        feed(4000, 0, 30, -1, 1'b0);
        reset = 1'b1;
        #1;
        chk("t5_async_ready", s_ready, 0);
        chk("t5_async_count", frame_count, 0);
        chk("t5_async_in_valid", in_valid, 0);
        chk("t5_async_wd_count", wd_frame_count, 0);
        step();
        reset = 1'b0;
        p0 = pulses;
        repeat (3) step();
        chk("t5_no_strobe", pulses - p0, 0);
        feed(5000, 0, 57, 56, 1'b0);
        issue_check("t5", 5000);
        finish_frame(2);

        // s_last on beat 20
        p0 = pulses;
        feed(6000, 0, 20, 19, 1'b0);
`ifdef TURBO_LLR_FRAME_CHECK_EN
        chk("t6_frame_err", frame_err, 1);
        chk("t6_still_fill", s_ready, 1);
        step();
        chk("t6_frame_err_end", frame_err, 0);
        feed(7000, 0, 57, 56, 1'b0);
        issue_check("t6", 7000);
`else
        chk("t6_frame_err_tied", frame_err, 0);
        feed(6000, 20, 57, 56, 1'b0);
        issue_check("t6", 6000);
`endif
        chk("t6_pulses", pulses - p0, 1);

        chk("no_stall", stalls, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
